// File: rtl/imem_program_loader.sv
// Instruction-memory preloader: streams words into IMEM, reads them back to
// verify a rotate/XOR checksum, then releases the core enable.
//
// state  | meaning
// IDLE   | waiting for start, core disabled
// LOAD   | accepting stream beats, one IMEM write per beat
// VERIFY | issuing one readback per cycle
// CHECK  | draining delayed read data, then comparing checksums
// RUN    | checksum matched, core enabled
// ERROR  | overflow or checksum mismatch, core disabled
module imem_program_loader #(
    parameter int          MAX_WORDS   = 128,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter int          ADDR_STRIDE = 4,
    parameter int          RD_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        start,
    input  logic        abort,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic        cpu_enable,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [7:0]  word_count,
    output logic [31:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_VERIFY, S_CHECK, S_RUN, S_ERROR
    } state_t;

    localparam logic [7:0]  MAX_W8  = 8'(MAX_WORDS);
    localparam logic [63:0] STRIDE  = 64'(ADDR_STRIDE);

    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic                  s_ready_q, s_ready_d;
    logic [63:0]           addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic                  ren_q, ren_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  cpu_en_q, cpu_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [1:0]            err_q, err_d;
    logic [7:0]            wc_q, wc_d;
    logic [31:0]           cs_q, cs_d;
    logic [7:0]            rd_idx_q, rd_idx_d;
    logic [7:0]            samp_cnt_q, samp_cnt_d;
    logic [31:0]           vsum_q, vsum_d;
    logic [RD_LATENCY-1:0] pipe_q, pipe_d;
    logic                  samp_valid;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        addr_d     = addr_q;
        wen_d      = 1'b0;
        ren_d      = 1'b0;
        wdata_d    = wdata_q;
        err_d      = err_q;
        wc_d       = wc_q;
        cs_d       = cs_q;
        rd_idx_d   = rd_idx_q;
        // pipe_q[i] marks that read data is valid i+1 cycles after the issue.
        pipe_d     = RD_LATENCY'({pipe_q, ren_q});
        samp_valid = pipe_q[RD_LATENCY-1];
        vsum_d     = vsum_q;
        samp_cnt_d = samp_cnt_q;
        if (samp_valid) begin
            vsum_d     = rotl1(vsum_q) ^ rdata_ext;
            samp_cnt_d = samp_cnt_q + 8'd1;
        end

        case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (start) begin
                    state_d = S_LOAD;
                    last_d  = 1'b0;
                    wc_d    = 8'd0;
                    cs_d    = 32'd0;
                    err_d   = 2'b00;
                end else if (state_q == S_RUN && abort) begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (last_q) begin
                    // Final write cycle is on the bus now; first readback goes next.
                    ren_d      = 1'b1;
                    addr_d     = BASE_ADDR;
                    rd_idx_d   = 8'd1;
                    vsum_d     = 32'd0;
                    samp_cnt_d = 8'd0;
                    state_d    = (wc_q == 8'd1) ? S_CHECK : S_VERIFY;
                end else if (s_valid && s_ready_q) begin
                    if (wc_q == MAX_W8) begin
                        state_d = S_ERROR;
                        err_d   = 2'b01;
                    end else begin
                        wen_d   = 1'b1;
                        addr_d  = BASE_ADDR + ({56'd0, wc_q} * STRIDE);
                        wdata_d = s_data;
                        cs_d    = rotl1(cs_q) ^ s_data;
                        wc_d    = wc_q + 8'd1;
                        last_d  = s_last;
                    end
                end
            end
            S_VERIFY: begin
                ren_d    = 1'b1;
                addr_d   = BASE_ADDR + ({56'd0, rd_idx_q} * STRIDE);
                rd_idx_d = rd_idx_q + 8'd1;
                if (rd_idx_d == wc_q) state_d = S_CHECK;
            end
            S_CHECK: begin
                // Compare against the sum including this cycle's sample, if any.
                if (samp_cnt_d == wc_q) begin
                    if (vsum_d == cs_q) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 2'b10;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        s_ready_d = (state_d == S_LOAD) && !last_d;
        busy_d    = (state_d == S_LOAD) || (state_d == S_VERIFY) || (state_d == S_CHECK);
        cpu_en_d  = (state_d == S_RUN);
        done_d    = (state_d == S_RUN);
        error_d   = (state_d == S_ERROR);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= S_IDLE;
            last_q     <= 1'b0;
            s_ready_q  <= 1'b0;
            addr_q     <= 64'd0;
            wen_q      <= 1'b0;
            ren_q      <= 1'b0;
            wdata_q    <= 32'd0;
            cpu_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_q      <= 2'b00;
            wc_q       <= 8'd0;
            cs_q       <= 32'd0;
            rd_idx_q   <= 8'd0;
            samp_cnt_q <= 8'd0;
            vsum_q     <= 32'd0;
            pipe_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            s_ready_q  <= s_ready_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            ren_q      <= ren_d;
            wdata_q    <= wdata_d;
            cpu_en_q   <= cpu_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_q      <= err_d;
            wc_q       <= wc_d;
            cs_q       <= cs_d;
            rd_idx_q   <= rd_idx_d;
            samp_cnt_q <= samp_cnt_d;
            vsum_q     <= vsum_d;
            pipe_q     <= pipe_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign addr_ext   = addr_q;
    assign wen_ext    = wen_q;
    assign ren_ext    = ren_q;
    assign wdata_ext  = wdata_q;
    assign cpu_enable = cpu_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_code   = err_q;
    assign word_count = wc_q;
    assign checksum   = cs_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader: IMEM model with optional readback corruption,
// stream driver, and a word-list reference model of the expected load outcome.
module tb_imem_program_loader;
    localparam int MAXW = 4;
    localparam int RDL  = 1;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = 32'd0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] rdata_ext = 32'd0;
    logic        cpu_enable, busy, done, error;
    logic [1:0]  err_code;
    logic [7:0]  word_count;
    logic [31:0] checksum;

    imem_program_loader #(
        .MAX_WORDS(MAXW), .BASE_ADDR(64'h0), .ADDR_STRIDE(4), .RD_LATENCY(RDL)
    ) dut (
        .clk(clk), .arst(arst), .start(start), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .cpu_enable(cpu_enable), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .word_count(word_count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int mis = 0;

    logic [31:0] imem [0:127];
    logic [63:0] wlog_addr[$];
    logic [31:0] wlog_data[$];
    int          wlog_cyc[$];
    int          nreads = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          corrupt_idx = -1;

    logic [31:0] stim[$];
    int          stim_last = -1;
    bit          rand_valid = 1'b0;
    logic [15:0] vpat = 16'hFFFF;
    int          vpat_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // IMEM model: registered read (latency 1), optional single-bit readback corruption.
    always @(posedge clk) begin
        if (wen_ext) begin
            imem[addr_ext[8:2]] <= wdata_ext;
            wlog_addr.push_back(addr_ext);
            wlog_data.push_back(wdata_ext);
            wlog_cyc.push_back(cyc);
            last_wr_cyc <= cyc;
        end
        if (ren_ext) begin
            rdata_ext <= imem[addr_ext[8:2]] ^
                         ((int'(addr_ext[8:2]) == corrupt_idx) ? 32'h1 : 32'h0);
            nreads <= nreads + 1;
        end
    end

    task automatic run_load(input string tag, input bit chk_b2b, input bit chk_ready_drop);
        bit          ovf, exp_done, v, took, acc_last;
        int          n_exp, idx, step, budget, lat, wbase, rbase, nw;
        logic [31:0] exp_cs;
        logic [1:0]  exp_err;

        ovf      = (stim_last < 0) || (stim_last >= MAXW);
        n_exp    = ovf ? MAXW : stim_last + 1;
        exp_cs   = 32'd0;
        for (int i = 0; i < n_exp; i++) exp_cs = ((exp_cs << 1) | (exp_cs >> 31)) ^ stim[i];
        exp_done = !ovf && !(corrupt_idx >= 0 && corrupt_idx < n_exp);
        exp_err  = ovf ? 2'b01 : (exp_done ? 2'b00 : 2'b10);

        wbase = wlog_data.size();
        rbase = nreads;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        vec++;
        if ({busy, s_ready, err_code, word_count, checksum} !== {1'b1, 1'b1, 2'b00, 8'd0, 32'd0}) begin
            mis++;
            $display("FAIL %s start_clear: busy=%b rdy=%b err=%b wc=%0d cs=%h, need 1 1 00 0 0",
                     tag, busy, s_ready, err_code, word_count, checksum);
        end

        idx = 0; step = 0; budget = 200; acc_last = 1'b0;
        while (!acc_last && idx < stim.size() && budget > 0 && !error) begin
            if (rand_valid)      v = ($urandom_range(0, 2) != 0);
            else if (vpat_len > 0) v = vpat[step % vpat_len];
            else                 v = 1'b1;
            step++;
            s_valid = v;
            s_data  = v ? stim[idx] : $urandom;
            s_last  = v && (idx == stim_last);
            took    = v && s_ready;
            @(negedge clk);
            budget--;
            if (took) begin
                if (idx == stim_last) acc_last = 1'b1;
                idx++;
            end
        end
        s_valid = 1'b0; s_last = 1'b0; s_data = 32'd0;
        vec++;
        if (budget == 0) begin
            mis++;
            $display("FAIL %s stream_timeout: sent %0d beats, need %0d", tag, idx, stim.size());
        end
        if (chk_ready_drop) begin
            vec++;
            if (s_ready !== 1'b0) begin
                mis++;
                $display("FAIL %s ready_drop: s_ready=%b need 0", tag, s_ready);
            end
        end

        for (int t = 0; t < 60 && !(done || error); t++) @(negedge clk);
        lat = cyc - last_wr_cyc;
        vec++;
        if ({done, error, cpu_enable, err_code} !== {exp_done, !exp_done, exp_done, exp_err}) begin
            mis++;
            $display("FAIL %s outcome: done=%b err=%b en=%b code=%b, need %b %b %b %b",
                     tag, done, error, cpu_enable, err_code, exp_done, !exp_done, exp_done, exp_err);
        end
        vec++;
        if (word_count !== 8'(n_exp)) begin
            mis++;
            $display("FAIL %s word_count: %0d need %0d", tag, word_count, n_exp);
        end
        vec++;
        if (checksum !== exp_cs) begin
            mis++;
            $display("FAIL %s checksum: %h need %h", tag, checksum, exp_cs);
        end
        nw = wlog_data.size() - wbase;
        vec++;
        if (nw !== n_exp) begin
            mis++;
            $display("FAIL %s write_count: %0d need %0d", tag, nw, n_exp);
        end
        for (int i = 0; i < nw && i < n_exp; i++) begin
            vec++;
            if (wlog_addr[wbase+i] !== 64'(i * 4) || wlog_data[wbase+i] !== stim[i]) begin
                mis++;
                $display("FAIL %s write%0d: addr=%h data=%h need addr=%h data=%h", tag, i,
                         wlog_addr[wbase+i], wlog_data[wbase+i], 64'(i * 4), stim[i]);
            end
        end
        vec++;
        if ((nreads - rbase) !== (ovf ? 0 : n_exp)) begin
            mis++;
            $display("FAIL %s read_count: %0d need %0d", tag, nreads - rbase, ovf ? 0 : n_exp);
        end
        if (exp_done) begin
            vec++;
            if (lat > n_exp + RDL + 2) begin
                mis++;
                $display("FAIL %s done_latency: %0d cycles after last write, need <= %0d",
                         tag, lat, n_exp + RDL + 2);
            end
        end
        if (chk_b2b) begin
            for (int i = 1; i < nw; i++) begin
                vec++;
                if (wlog_cyc[wbase+i] !== wlog_cyc[wbase] + i) begin
                    mis++;
                    $display("FAIL %s b2b_write%0d: cycle %0d need %0d", tag, i,
                             wlog_cyc[wbase+i], wlog_cyc[wbase] + i);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vec++;
        if ({s_ready, wen_ext, ren_ext, cpu_enable, busy, done, error, err_code,
             word_count, checksum, addr_ext, wdata_ext} !== '0) begin
            mis++;
            $display("FAIL reset_hold: outputs not all zero (busy=%b wc=%0d)", busy, word_count);
        end
        arst = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) begin start = 1'b0; s_valid = 1'b1; s_data = 32'hDEAD0001; end
        @(negedge clk) s_data = 32'hDEAD0002;
        @(negedge clk) s_valid = 1'b0;
        vec++;
        if (word_count !== 8'd2 || wen_ext !== 1'b1) begin
            mis++;
            $display("FAIL pre_reset_load: wc=%0d wen=%b need 2 1", word_count, wen_ext);
        end
        #2 arst = 1'b1;
        #1;
        vec++;
        if ({s_ready, wen_ext, ren_ext, cpu_enable, busy, done, error, err_code,
             word_count, checksum, addr_ext, wdata_ext} !== '0) begin
            mis++;
            $display("FAIL reset_midload: busy=%b rdy=%b wen=%b wc=%0d cs=%h addr=%h, need all 0",
                     busy, s_ready, wen_ext, word_count, checksum, addr_ext);
        end
        @(negedge clk) arst = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        vec++;
        if ({busy, s_ready, word_count} !== {1'b1, 1'b1, 8'd0}) begin
            mis++;
            $display("FAIL restart: busy=%b rdy=%b wc=%0d need 1 1 0", busy, s_ready, word_count);
        end
        arst = 1'b1;
        @(negedge clk) arst = 1'b0;
    endtask

    task automatic test_basic();
        stim = '{32'h00000013, 32'h00100093, 32'h00208113};
        stim_last = 2; corrupt_idx = -1; rand_valid = 1'b0; vpat_len = 0;
        run_load("basic", 1'b1, 1'b0);
        vec++;
        if (checksum !== 32'h00008079) begin
            mis++;
            $display("FAIL basic_cs_const: %h need 00008079", checksum);
        end
    endtask

    task automatic test_abort();
        repeat (2) @(negedge clk);
        vec++;
        if ({cpu_enable, done} !== 2'b11) begin
            mis++;
            $display("FAIL run_hold: en=%b done=%b need 1 1", cpu_enable, done);
        end
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        vec++;
        if ({cpu_enable, done, busy, error} !== 4'b0000) begin
            mis++;
            $display("FAIL abort: en=%b done=%b busy=%b err=%b need 0 0 0 0",
                     cpu_enable, done, busy, error);
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        vec++;
        if ({busy, s_ready} !== 2'b11) begin
            mis++;
            $display("FAIL abort_restart: busy=%b rdy=%b need 1 1", busy, s_ready);
        end
        // start during LOAD must be ignored: word count stays put
        s_valid = 1'b1; s_data = 32'h12345678;
        @(negedge clk) begin s_valid = 1'b0; start = 1'b1; end
        @(negedge clk) start = 1'b0;
        vec++;
        if (word_count !== 8'd1) begin
            mis++;
            $display("FAIL start_in_load: wc=%0d need 1", word_count);
        end
        arst = 1'b1;
        @(negedge clk) arst = 1'b0;
    endtask

    task automatic test_corrupt();
        stim = '{32'h00000013, 32'h00100093, 32'h00208113};
        stim_last = 2; corrupt_idx = 1; rand_valid = 1'b0; vpat_len = 0;
        run_load("corrupt", 1'b0, 1'b0);
        corrupt_idx = -1;
    endtask

    task automatic test_overflow();
        stim.delete();
        for (int i = 0; i < MAXW + 1; i++) stim.push_back($urandom);
        stim_last = -1; corrupt_idx = -1; rand_valid = 1'b0; vpat_len = 0;
        run_load("overflow", 1'b1, 1'b0);
    endtask

    task automatic test_valid_pattern();
        stim.delete();
        for (int i = 0; i < 4; i++) stim.push_back($urandom);
        stim_last = 3; corrupt_idx = -1; rand_valid = 1'b0;
        vpat = 16'b101101; vpat_len = 6;
        run_load("vpattern", 1'b0, 1'b1);
        vpat_len = 0;
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 8; it++) begin
            stim.delete();
            if ($urandom_range(0, 3) == 0) begin
                n = MAXW + 1;
                stim_last = -1;
            end else begin
                n = $urandom_range(1, MAXW);
                stim_last = n - 1;
            end
            for (int i = 0; i < n; i++) stim.push_back($urandom);
            corrupt_idx = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
            rand_valid = 1'b1;
            run_load($sformatf("random%0d", it), 1'b0, 1'b0);
        end
        rand_valid = 1'b0; corrupt_idx = -1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_abort();
        test_corrupt();
        test_overflow();
        test_valid_pattern();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Upstream feeder of the pipelined RISC-V core: accepts a stream of 32-bit instruction words, writes them into the core's instruction memory through its external port, reads them back to verify a checksum, then drives the core's enable.
- Sits between the host/testbench stream source and the core's addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext/enable pins.
- Replaces hand-sequenced memory preload with one handshake-driven FSM.

Parameters:
MAX_WORDS, 128, capacity in words; a 9-bit byte-addressed IMEM holds 128 words.
BASE_ADDR, 64'h0, byte address of the first word.
ADDR_STRIDE, 4, byte increment per word.
RD_LATENCY, 1, cycles from ren_ext/addr_ext to valid rdata_ext (1..3).

Ports:
clk  input  1  main clock, rising edge
arst  input  1  asynchronous reset, active-high
start  input  1  one-cycle pulse: begin load; accepted in IDLE, RUN or ERROR
abort  input  1  level: leave RUN, deassert cpu_enable
s_valid  input  1  stream word valid
s_data  input  32  stream instruction word
s_last  input  1  marks final word of program
s_ready  output  1  loader can accept a word
addr_ext  output  64  IMEM external address
wen_ext  output  1  IMEM external write enable
ren_ext  output  1  IMEM external read enable
wdata_ext  output  32  IMEM external write data
rdata_ext  input  32  IMEM external read data
cpu_enable  output  1  drives core enable
busy  output  1  state is LOAD, VERIFY or CHECK
done  output  1  verify passed (level, state RUN)
error  output  1  level, state ERROR
err_code  output  2  00 none, 01 overflow, 10 checksum mismatch
word_count  output  8  words accepted in current load
checksum  output  32  load-side running checksum

Behaviour:
- All outputs are registered. Reset (arst=1, asynchronous) forces:
  - state IDLE;
  - addr_ext, wdata_ext, word_count, checksum and err_code to 0;
  - s_ready, wen_ext, ren_ext, cpu_enable, busy, done and error to 0.
- Reset asserted mid-operation aborts immediately. No partial-write completion is guaranteed.
- States: IDLE, LOAD, VERIFY, CHECK, RUN, ERROR.
- IDLE/RUN/ERROR + start → LOAD next cycle:
  - clears word_count, checksum and err_code;
  - cpu_enable drops in that same edge.
- start during LOAD/VERIFY/CHECK is ignored.
- LOAD:
  - s_ready=1 while in LOAD. A beat transfers on s_valid&&s_ready.
  - A transfer of word k (0-based) produces, in the following cycle, exactly one cycle of wen_ext=1, addr_ext=BASE_ADDR+k*ADDR_STRIDE and wdata_ext=s_data.
  - Back-to-back beats give back-to-back writes. No bubbles are required.
  - Checksum update per accepted word: checksum = rotl1(checksum) ^ s_data, 32-bit.
  - word_count increments per accepted word.
  - Beat with s_last=1: s_ready drops the next cycle; state → VERIFY after that word's write cycle.
  - Overflow: a beat accepted when word_count==MAX_WORDS without a prior s_last is not written. State → ERROR, err_code=01.
  - s_last on word MAX_WORDS-1 (0-based) is legal.
- VERIFY:
  - Issues word_count reads, one per cycle: ren_ext=1, addr_ext stepping from BASE_ADDR.
  - rdata_ext is sampled RD_LATENCY cycles after each read and accumulated into an internal verify checksum with the same rotl1/XOR rule.
  - wen_ext=0 throughout.
  - After the last issue, state → CHECK.
- CHECK:
  - Waits until all RD_LATENCY-delayed samples are accumulated, then compares the two checksums.
  - Equal → RUN. Unequal → ERROR with err_code=10.
- RUN: cpu_enable=1, done=1. abort=1 → IDLE next cycle with cpu_enable=0.
- ERROR: error=1, cpu_enable=0. Leaves only on start or reset.
- Empty program: not possible, since the first accepted beat counts even if s_last=1.
- Address width: full 64-bit arithmetic, no wrap handling; MAX_WORDS bounds the address.

Test Plan:
1. Reset with arst=1 mid-LOAD, after 2 beats → all outputs 0, state IDLE; a following start restarts with word_count=0.
2. Load 0x00000013, 0x00100093, 0x00208113 (last on third), memory model RD_LATENCY=1:
   - three writes at addr 0, 4, 8;
   - checksum=0x00008079;
   - 3 reads;
   - done=1 and cpu_enable=1 within 3+RD_LATENCY+2 cycles of the last write.
3. Same stream, but the memory model corrupts word 1 on readback → error=1, err_code=10, cpu_enable stays 0.
4. MAX_WORDS=4, stream 5 beats with no s_last → 4 writes, then ERROR with err_code=01; the fifth word is never written.
5. s_valid toggling 1,0,1,1,0,1 with s_last on the 4th beat → writes only on accepted beats, addresses contiguous, s_ready low after the last beat.
6. In RUN: abort=1 → cpu_enable=0 next cycle, state IDLE; then start → LOAD and busy=1 on the following cycle.
